spi_slave_fifo: RTL and testbench

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

---
 rtl/spi_slave_fifo.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fifo.sv
// -----------------------------------------------------------------------------
// spi_slave_fifo
//   SPI slave with a TX and an RX FIFO on the system-clock side. The SPI pins
//   are asynchronous to clk and are oversampled (clk >= 4x sclk). Words are
//   WIDTH bits, MSB first. All four SPI modes are selected by CPOL/CPHA.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   sclk, mosi, ce0       SPI inputs from the master (ce0 active low)
//   miso                  SPI output to the master (0 while idle)
//   tx_data/valid/ready   push side of the TX FIFO (ready = not full)
//   rx_data/valid/ready   pop side of the RX FIFO (first-word fall-through)
//   tx_level, rx_level    FIFO occupancy
//   rx_overrun            received word dropped because the RX FIFO was full
//   tx_underrun           frame word started with an empty TX FIFO (FILL sent)
//   frame_error           ce0 deasserted in the middle of a word
//
// spi_slave_fifo_buf
//   Synchronous FIFO used for both directions. Callers qualify wr_en/rd_en;
//   rd_data reads 0 while empty.
// -----------------------------------------------------------------------------

module spi_slave_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // The extra pointer MSB distinguishes full from empty when indices match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: the storage array has no reset; only the pointers decide what is
    // valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

module spi_slave_fifo #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 16,
    parameter bit               CPOL  = 1'b0,
    parameter bit               CPHA  = 1'b0,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    mosi,
    input  logic                    ce0,
    output logic                    miso,
    input  logic [WIDTH-1:0]        tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [WIDTH-1:0]        rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  tx_level,
    output logic [$clog2(DEPTH):0]  rx_level,
    output logic                    rx_overrun,
    output logic                    tx_underrun,
    output logic                    frame_error
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [CW-1:0]    bit_cnt;
    logic             word_done;     // WIDTH bits captured, push pending

    // ------------------------------------------------------------------
    // Input synchronizers: two flops each plus a history flop
    // ------------------------------------------------------------------
    logic sclk_meta, sclk_sync, sclk_prev;
    logic mosi_meta, mosi_sync, mosi_prev;
    logic ce0_meta,  ce0_sync,  ce0_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_meta <= 1'b0; sclk_sync <= 1'b0; sclk_prev <= 1'b0;
            mosi_meta <= 1'b0; mosi_sync <= 1'b0; mosi_prev <= 1'b0;
            ce0_meta  <= 1'b0; ce0_sync  <= 1'b0; ce0_prev  <= 1'b0;
        end else begin
            sclk_meta <= sclk; sclk_sync <= sclk_meta; sclk_prev <= sclk_sync;
            mosi_meta <= mosi; mosi_sync <= mosi_meta; mosi_prev <= mosi_sync;
            ce0_meta  <= ce0;  ce0_sync  <= ce0_meta;  ce0_prev  <= ce0_sync;
        end
    end

    // Because ce0 synchronizers reset to 0, a ce0 held low through reset is
    // never seen as a falling edge: a frame needs a fresh ce0 fall after reset.
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ce0_fall, ce0_rise;

    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign sclk_fall   = ~sclk_sync & sclk_prev;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign ce0_fall    = ~ce0_sync & ce0_prev;
    assign ce0_rise    = ce0_sync & ~ce0_prev;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic             tx_full, tx_empty, tx_wr, tx_rd;
    logic [WIDTH-1:0] tx_head, load_word;
    logic             rx_full, rx_empty, rx_wr, rx_rd, rx_push_req;

    assign tx_ready    = ~tx_full;
    assign tx_wr       = tx_valid & ~tx_full;
    assign tx_rd       = (state == LOAD) & ~tx_empty;
    assign load_word   = tx_empty ? FILL : tx_head;

    assign rx_valid    = ~rx_empty;
    assign rx_rd       = rx_ready & ~rx_empty;
    assign rx_push_req = (state == SHIFT) & word_done;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_wr       = rx_push_req & (~rx_full | rx_rd);

    spi_slave_fifo_buf #(.W(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (tx_rd),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    spi_slave_fifo_buf #(.W(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (rx_shift),
        .rd_en   (rx_rd),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    // ------------------------------------------------------------------
    // Frame FSM with registered miso and event pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            miso        <= 1'b0;
            frame_error <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= rx_push_req & rx_full & ~rx_rd;

            unique case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (ce0_fall) state <= LOAD;
                end

                LOAD: begin
                    bit_cnt     <= '0;
                    word_done   <= 1'b0;
                    rx_shift    <= '0;
                    tx_underrun <= tx_empty;
                    if (ce0_rise) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                    end else begin
                        state <= SHIFT;
                        // CPHA=0 presents the MSB right away. CPHA=1 waits for
                        // the first leading edge, which can already land here
                        // on back-to-back words at the minimum clk ratio.
                        if (!CPHA || shift_edge) begin
                            miso     <= load_word[WIDTH-1];
                            tx_shift <= load_word << 1;
                        end else begin
                            miso     <= 1'b0;
                            tx_shift <= load_word;
                        end
                    end
                end

                SHIFT: begin
                    if (word_done) begin
                        // Push happens this cycle through rx_wr.
                        word_done <= 1'b0;
                        if (ce0_sync) begin
                            state <= IDLE;
                            miso  <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (ce0_rise) begin
                        frame_error <= (bit_cnt != '0);
                        state       <= IDLE;
                        miso        <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            // mosi_prev is aligned with sclk_prev: the data
                            // level just before the sampling edge.
                            rx_shift <= {rx_shift[WIDTH-2:0], mosi_prev};
                            bit_cnt  <= bit_cnt + CW'(1);
                            if (bit_cnt == CW'(WIDTH - 1)) word_done <= 1'b1;
                        end
                        // With CPHA=0 a trailing edge at bit count 0 is the
                        // tail of the previous word, not a shift request.
                        if (shift_edge && (CPHA || bit_cnt != '0)) begin
                            miso     <= tx_shift[WIDTH-1];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_fifo
//   Directed bench for spi_slave_fifo. One DUT per SPI mode (index = mode =
//   {CPOL,CPHA}), all WIDTH=8, DEPTH=16, FILL=0xFF. A behavioural SPI master
//   drives the selected instance; expected master-received words and expected
//   RX words are queued when stimulus is issued and compared when produced.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_slave_fifo;
    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic       sclk_v      [4];
    logic       ce0_v       [4];
    logic       tx_valid_v  [4];
    logic       rx_ready_v  [4];
    logic       mosi;
    logic [7:0] tx_data;

    logic       miso_v        [4];
    logic       tx_ready_v    [4];
    logic       rx_valid_v    [4];
    logic       rx_overrun_v  [4];
    logic       tx_underrun_v [4];
    logic       frame_error_v [4];
    logic [7:0] rx_data_v     [4];
    logic [4:0] tx_level_v    [4];
    logic [4:0] rx_level_v    [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_fifo #(
            .WIDTH (8),
            .DEPTH (16),
            .CPOL  (g >= 2),
            .CPHA  (g % 2 == 1),
            .FILL  (8'hFF)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .sclk        (sclk_v[g]),
            .mosi        (mosi),
            .ce0         (ce0_v[g]),
            .miso        (miso_v[g]),
            .tx_data     (tx_data),
            .tx_valid    (tx_valid_v[g]),
            .tx_ready    (tx_ready_v[g]),
            .rx_data     (rx_data_v[g]),
            .rx_valid    (rx_valid_v[g]),
            .rx_ready    (rx_ready_v[g]),
            .tx_level    (tx_level_v[g]),
            .rx_level    (rx_level_v[g]),
            .rx_overrun  (rx_overrun_v[g]),
            .tx_underrun (tx_underrun_v[g]),
            .frame_error (frame_error_v[g])
        );
    end

    // Event pulse counters
    int und_cnt [4] = '{default: 0};
    int ovr_cnt [4] = '{default: 0};
    int fe_cnt  [4] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (tx_underrun_v[i]) und_cnt[i]++;
            if (rx_overrun_v[i])  ovr_cnt[i]++;
            if (frame_error_v[i]) fe_cnt[i]++;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_miso [$];
    logic [7:0] exp_rx   [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Half an SPI clock period: sclk runs at clk/16.
    task automatic half();
        cyc(8);
    endtask

    task automatic tx_push(input int m, input logic [7:0] d);
        check($sformatf("m%0d_tx_ready", m), tx_ready_v[m], 1);
        tx_data       = d;
        tx_valid_v[m] = 1'b1;
        cyc(1);
        tx_valid_v[m] = 1'b0;
        exp_miso.push_back(d);
    endtask

    task automatic rx_pop(input int m);
        check($sformatf("m%0d_rx_sb_depth", m), exp_rx.size() > 0, 1);
        check($sformatf("m%0d_rx_valid", m), rx_valid_v[m], 1);
        if (exp_rx.size() > 0)
            check($sformatf("m%0d_rx_data", m), rx_data_v[m], exp_rx.pop_front());
        rx_ready_v[m] = 1'b1;
        cyc(1);
        rx_ready_v[m] = 1'b0;
    endtask

    // One bit of a master transfer; on the last bit ce0 is released one clk
    // after the final sampling edge so no further word is loaded.
    task automatic spi_bit(input int m, input logic bo, output logic bi, input bit last);
        bit cpol;
        bit cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        if (!cpha) begin
            mosi = bo;
            half();
            sclk_v[m] = ~cpol;
            bi = miso_v[m];
            if (last) begin cyc(1); ce0_v[m] = 1'b1; end
            half();
            sclk_v[m] = cpol;
        end else begin
            sclk_v[m] = ~cpol;
            mosi = bo;
            half();
            bi = miso_v[m];
            sclk_v[m] = cpol;
            if (last) begin cyc(1); ce0_v[m] = 1'b1; end
            half();
        end
    endtask

    task automatic spi_frame(input int m, input int n, input logic [7:0] w0,
                             input logic [7:0] w1, input logic [7:0] w2, input bit rx_expected);
        logic [7:0] ws [3];
        logic [7:0] mi;
        logic       b;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        mi = '0;
        ce0_v[m] = 1'b0;
        half();
        for (int w = 0; w < n; w++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_bit(m, ws[w][i], b, (w == n - 1) && (i == 0));
                mi[i] = b;
            end
            check($sformatf("m%0d_miso_sb_depth", m), exp_miso.size() > 0, 1);
            if (exp_miso.size() > 0)
                check($sformatf("m%0d_miso_word%0d", m, w), mi, exp_miso.pop_front());
            if (rx_expected) exp_rx.push_back(ws[w]);
        end
        half();
        half();
    endtask

    task automatic spi_partial(input int m, input int nbits);
        logic b;
        ce0_v[m] = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) spi_bit(m, 1'b1, b, 1'b0);
        half();
        ce0_v[m] = 1'b1;
        half();
        half();
    endtask

    initial begin
        int snap;
        logic b;

        reset   = 1'b1;
        mosi    = 1'b0;
        tx_data = '0;
        for (int i = 0; i < 4; i++) begin
            sclk_v[i]     = (i >= 2);
            ce0_v[i]      = 1'b1;
            tx_valid_v[i] = 1'b0;
            rx_ready_v[i] = 1'b0;
        end
        cyc(3);

        // Reset state
        check("rst_miso",     miso_v[0],     0);
        check("rst_tx_ready", tx_ready_v[0], 1);
        check("rst_rx_valid", rx_valid_v[0], 0);
        check("rst_tx_level", tx_level_v[0], 0);
        check("rst_rx_level", rx_level_v[0], 0);
        check("rst_rx_data",  rx_data_v[0],  0);
        reset = 1'b0;
        cyc(4);

        // Basic exchange in all four modes
        for (int m = 0; m < 4; m++) begin
            snap = und_cnt[m];
            tx_push(m, 8'hA5);
            check($sformatf("m%0d_tx_level_pre", m), tx_level_v[m], 1);
            spi_frame(m, 1, 8'h3C, 8'h00, 8'h00, 1'b1);
            check($sformatf("m%0d_rx_level", m), rx_level_v[m], 1);
            check($sformatf("m%0d_tx_level_post", m), tx_level_v[m], 0);
            check($sformatf("m%0d_underruns", m), und_cnt[m] - snap, 0);
            rx_pop(m);
            check($sformatf("m%0d_rx_level_drained", m), rx_level_v[m], 0);
        end

        // Empty TX: FILL is sent, one underrun pulse
        snap = und_cnt[0];
        exp_miso.push_back(8'hFF);
        spi_frame(0, 1, 8'h5A, 8'h00, 8'h00, 1'b1);
        check("fill_underruns", und_cnt[0] - snap, 1);
        rx_pop(0);

        // RX overrun: fill 16 words, 17th is dropped
        for (int i = 0; i < 16; i++) begin
            exp_miso.push_back(8'hFF);
            spi_frame(0, 1, 8'(i * 17 + 3), 8'h00, 8'h00, 1'b1);
        end
        check("ovr_full_level", rx_level_v[0], 16);
        snap = ovr_cnt[0];
        exp_miso.push_back(8'hFF);
        spi_frame(0, 1, 8'hEE, 8'h00, 8'h00, 1'b0);
        check("ovr_pulses", ovr_cnt[0] - snap, 1);
        check("ovr_level",  rx_level_v[0], 16);
        check("ovr_head",   rx_data_v[0], exp_rx[0]);
        for (int i = 0; i < 16; i++) rx_pop(0);
        check("ovr_drained", rx_level_v[0], 0);

        // Frame error after 3 bits, then a clean frame
        snap = fe_cnt[0];
        spi_partial(0, 3);
        check("ferr_pulses", fe_cnt[0] - snap, 1);
        check("ferr_level",  rx_level_v[0], 0);
        exp_miso.push_back(8'hFF);
        spi_frame(0, 1, 8'hC3, 8'h00, 8'h00, 1'b1);
        check("ferr_next_level", rx_level_v[0], 1);
        rx_pop(0);

        // Back-to-back words with ce0 held low
        tx_push(0, 8'h01);
        tx_push(0, 8'h02);
        tx_push(0, 8'h03);
        snap = und_cnt[0];
        spi_frame(0, 3, 8'h11, 8'h22, 8'h33, 1'b1);
        check("b2b_rx_level", rx_level_v[0], 3);
        check("b2b_tx_level", tx_level_v[0], 0);
        check("b2b_underruns", und_cnt[0] - snap, 0);
        for (int i = 0; i < 3; i++) rx_pop(0);

        // Reset mid-frame: no frame error, frame does not resume
        snap = fe_cnt[0];
        ce0_v[0] = 1'b0;
        half();
        for (int i = 0; i < 3; i++) spi_bit(0, 1'b0, b, 1'b0);
        reset = 1'b1;
        cyc(2);
        check("midrst_miso", miso_v[0], 0);
        reset = 1'b0;
        half();
        ce0_v[0] = 1'b1;
        half();
        half();
        check("midrst_ferr",     fe_cnt[0] - snap, 0);
        check("midrst_rx_level", rx_level_v[0], 0);
        exp_miso.push_back(8'hFF);
        spi_frame(0, 1, 8'h96, 8'h00, 8'h00, 1'b1);
        rx_pop(0);

        check("miso_sb_left", exp_miso.size(), 0);
        check("rx_sb_left",   exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
